rv_hazard_scoreboard: RTL
=========================

RV_HAZARD_SCOREBOARD -- requirements
Module: rv_hazard_scoreboard

Interface
REQ-001 Parameter NUM_FWD, default 2, number of forwarding stages; index 0 is nearest EX (MEM), then WB, and so on.
REQ-002 Parameter RF_AW, default 5, register address width.
REQ-003 Parameter MC_DEPTH, default 4, maximum outstanding multicycle ops (range 1..15).
REQ-004 Derived SELW = clog2(NUM_FWD+1).
REQ-005 i_clk  in  1  single clock; all state updates on rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_haz_rf_ra1_ex, i_haz_rf_ra2_ex  in  RF_AW each  EX-stage source addresses.
REQ-008 i_haz_fwd_wa  in  NUM_FWD*RF_AW  dest address per stage; stage k occupies bits [k*RF_AW +: RF_AW].
REQ-009 i_haz_fwd_we  in  NUM_FWD  write enable per stage.
REQ-010 i_haz_fwd_is_load  in  NUM_FWD  per stage: result not yet available (load in flight).
REQ-011 i_haz_mc_issue  in  1  EX instruction is a multicycle op (e.g. divide).
REQ-012 i_haz_mc_wa  in  RF_AW  destination of the issuing op.
REQ-013 i_haz_mc_done  in  1  a multicycle op writes the RF at this edge.
REQ-014 i_haz_mc_done_wa  in  RF_AW  destination of the completing op.
REQ-015 i_haz_mc_kill  in  1  abort all outstanding multicycle ops.
REQ-016 o_haz_rf_rd1_sel, o_haz_rf_rd2_sel  out  SELW each  0 = RF read data; k+1 = forward from stage k.
REQ-017 o_haz_stall  out  1  freeze IF/ID/EX, insert bubble into MEM.
REQ-018 o_haz_pending  out  2**RF_AW  scoreboard busy bit per register.
REQ-019 o_haz_mc_cnt  out  4  outstanding multicycle op count.
REQ-020 o_haz_stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-021 Forwarding select SHALL be combinational; for each source, the lowest index k with fwd_we[k]=1 and fwd_wa[k]==source SHALL win; with no match, sel=0.
REQ-022 A source address of 0 SHALL never forward or stall (sel=0).
REQ-023 Load-use: stall SHALL assert when the winning stage k for either source has fwd_is_load[k]=1; non-winning stages SHALL be ignored.
REQ-024 Scoreboard: stall SHALL assert when either nonzero source has its o_haz_pending bit set, including in the cycle mc_done targets it; the bit clears at that edge and the RF supplies the value next cycle.
REQ-025 WAW: stall SHALL assert when mc_issue=1 and pending[mc_wa]=1.
REQ-026 Structural: stall SHALL assert when mc_issue=1 and o_haz_mc_cnt==MC_DEPTH, unless mc_done=1 in the same cycle.
REQ-027 An issue is accepted only when mc_issue=1, stall=0 and mc_wa!=0; on acceptance, pending[mc_wa] sets at the next edge.
REQ-028 mc_done SHALL clear pending[mc_done_wa] at the next edge and decrement the count; done with count 0 SHALL be ignored (no underflow).
REQ-029 Simultaneous accepted issue and done: the count SHALL stay unchanged; if the addresses match, pending stays set (issue wins).
REQ-030 mc_kill SHALL clear all pending bits and the count at the next edge, overriding same-cycle issue and done; the stall for that cycle is still computed from current state.
REQ-031 o_haz_stall_cnt SHALL increment each cycle stall=1 and saturate at 16'hFFFF.
REQ-032 o_haz_mc_cnt SHALL equal popcount of accepted, uncompleted, unkilled issues; an implementation SHALL NOT exceed MC_DEPTH.

Reset
REQ-033 While i_rst=1: o_haz_pending=0, o_haz_mc_cnt=0, o_haz_stall_cnt=0 at the next edge.
REQ-034 While i_rst=1: o_haz_stall SHALL be forced 0 and no issue SHALL be accepted.
REQ-035 Reset asserted mid-operation SHALL discard all outstanding ops; a later mc_done SHALL be ignored because the count is 0.

Verification
REQ-036 ra1=5, stage0 wa=5 we=1, stage1 wa=5 we=1 -> rd1_sel=1, stall=0; with stage0 we=0 -> rd1_sel=2.
REQ-037 ra2=7, stage0 wa=7 we=1 is_load=1 -> stall=1, stall_cnt increments by 1; next cycle stage1 matches (is_load=0) -> rd2_sel=2, stall=0.
REQ-038 Issue with wa=3 accepted -> pending[3]=1, cnt=1; ra1=3 -> stall=1 until the cycle of done wa=3 (inclusive); then pending[3]=0 and stall=0 the following cycle.
REQ-039 With MC_DEPTH=4, issue to regs 1..4, then a fifth issue -> stall=1, cnt holds 4; the same fifth issue with done wa=1 in that cycle -> accepted, cnt stays 4.
REQ-040 ra1=0 with all stages wa=0 we=1 is_load=1 -> rd1_sel=0, stall=0; issue with wa=0 -> cnt unchanged.
REQ-041 Two pending ops, then mc_kill together with issue wa=9 -> pending=0 and cnt=0 next cycle; a following done -> cnt stays 0.

Source files
------------

// File: rtl/rv_hazard_scoreboard_if.sv
// Hazard unit bus: EX source addresses, forwarding-stage state and multicycle
// issue/complete traffic in; forwarding selects, stall and scoreboard state out.
interface rv_hazard_scoreboard_if #(
  parameter int NUM_FWD = 2,
  parameter int RF_AW   = 5,
  parameter int SELW    = $clog2(NUM_FWD + 1)
);
  logic [RF_AW-1:0]         i_haz_rf_ra1_ex;
  logic [RF_AW-1:0]         i_haz_rf_ra2_ex;
  logic [NUM_FWD*RF_AW-1:0] i_haz_fwd_wa;
  logic [NUM_FWD-1:0]       i_haz_fwd_we;
  logic [NUM_FWD-1:0]       i_haz_fwd_is_load;
  logic                     i_haz_mc_issue;
  logic [RF_AW-1:0]         i_haz_mc_wa;
  logic                     i_haz_mc_done;
  logic [RF_AW-1:0]         i_haz_mc_done_wa;
  logic                     i_haz_mc_kill;
  logic [SELW-1:0]          o_haz_rf_rd1_sel;
  logic [SELW-1:0]          o_haz_rf_rd2_sel;
  logic                     o_haz_stall;
  logic [2**RF_AW-1:0]      o_haz_pending;
  logic [3:0]               o_haz_mc_cnt;
  logic [15:0]              o_haz_stall_cnt;

  modport master (
    output i_haz_rf_ra1_ex, i_haz_rf_ra2_ex, i_haz_fwd_wa, i_haz_fwd_we,
           i_haz_fwd_is_load, i_haz_mc_issue, i_haz_mc_wa, i_haz_mc_done,
           i_haz_mc_done_wa, i_haz_mc_kill,
    input  o_haz_rf_rd1_sel, o_haz_rf_rd2_sel, o_haz_stall, o_haz_pending,
           o_haz_mc_cnt, o_haz_stall_cnt
  );

  modport slave (
    input  i_haz_rf_ra1_ex, i_haz_rf_ra2_ex, i_haz_fwd_wa, i_haz_fwd_we,
           i_haz_fwd_is_load, i_haz_mc_issue, i_haz_mc_wa, i_haz_mc_done,
           i_haz_mc_done_wa, i_haz_mc_kill,
    output o_haz_rf_rd1_sel, o_haz_rf_rd2_sel, o_haz_stall, o_haz_pending,
           o_haz_mc_cnt, o_haz_stall_cnt
  );
endinterface

// File: rtl/rv_hazard_scoreboard.sv
// RISC-V EX-stage hazard unit: priority forwarding select, load-use detection and
// a per-register scoreboard for multicycle ops with a saturating stall counter.
module rv_hazard_fwd_sel #(
  parameter int NUM_FWD = 2,
  parameter int RF_AW   = 5,
  parameter int SELW    = 2
) (
  input  logic [RF_AW-1:0]                ra,
  input  logic [NUM_FWD-1:0][RF_AW-1:0]   wa,
  input  logic [NUM_FWD-1:0]              we,
  input  logic [NUM_FWD-1:0]              is_load,
  output logic [SELW-1:0]                 sel,
  output logic                            load_hit
);
  // Scan from the oldest stage down so the youngest (lowest index) match wins.
  always_comb begin
    sel      = '0;
    load_hit = 1'b0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (ra != '0 && we[k] && wa[k] == ra) begin
        sel      = SELW'(k + 1);
        load_hit = is_load[k];
      end
    end
  end
endmodule

module rv_hazard_scoreboard #(
  parameter int NUM_FWD  = 2,
  parameter int RF_AW    = 5,
  parameter int MC_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rv_hazard_scoreboard_if.slave haz
);
  localparam int SELW = $clog2(NUM_FWD + 1);
  localparam int NREG = 2**RF_AW;

  logic [1:0][RF_AW-1:0] src;
  logic [1:0][SELW-1:0]  sel;
  logic [1:0]            load_hit;
  logic [NREG-1:0]       pending, pend_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic [15:0]           stall_cnt;
  logic                  raw, waw, full, stall, accept, done_eff;

  assign src = {haz.i_haz_rf_ra2_ex, haz.i_haz_rf_ra1_ex};

  for (genvar s = 0; s < 2; s++) begin : g_src
    rv_hazard_fwd_sel #(.NUM_FWD(NUM_FWD), .RF_AW(RF_AW), .SELW(SELW)) u_sel (
      .ra       (src[s]),
      .wa       (haz.i_haz_fwd_wa),
      .we       (haz.i_haz_fwd_we),
      .is_load  (haz.i_haz_fwd_is_load),
      .sel      (sel[s]),
      .load_hit (load_hit[s])
    );
  end

  assign raw  = (src[0] != '0 && pending[src[0]]) || (src[1] != '0 && pending[src[1]]);
  assign waw  = haz.i_haz_mc_issue && pending[haz.i_haz_mc_wa];
  assign full = haz.i_haz_mc_issue && cnt == 4'(MC_DEPTH) && !haz.i_haz_mc_done;

  // Stall is gated by reset so nothing upstream freezes and nothing is accepted.
  assign stall    = !i_rst && (|load_hit || raw || waw || full);
  assign accept   = !i_rst && haz.i_haz_mc_issue && !stall && haz.i_haz_mc_wa != '0;
  assign done_eff = haz.i_haz_mc_done && cnt != '0;

  // Clear before set so an issue to the register completing this cycle stays pending.
  always_comb begin
    pend_nxt = pending;
    if (done_eff) pend_nxt[haz.i_haz_mc_done_wa] = 1'b0;
    if (accept)   pend_nxt[haz.i_haz_mc_wa]      = 1'b1;
    cnt_nxt = cnt;
    if (accept && !done_eff)      cnt_nxt = cnt + 4'd1;
    else if (!accept && done_eff) cnt_nxt = cnt - 4'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || haz.i_haz_mc_kill) begin
      pending <= '0;
      cnt     <= '0;
    end else begin
      pending <= pend_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                            stall_cnt <= '0;
    else if (stall && stall_cnt != '1)    stall_cnt <= stall_cnt + 16'd1;
  end

  assign haz.o_haz_rf_rd1_sel = sel[0];
  assign haz.o_haz_rf_rd2_sel = sel[1];
  assign haz.o_haz_stall      = stall;
  assign haz.o_haz_pending    = pending;
  assign haz.o_haz_mc_cnt     = cnt;
  assign haz.o_haz_stall_cnt  = stall_cnt;
endmodule
